// File: rtl/corona_pkg.sv
// Shared types and constants for the corona object pipeline: object count,
// the "no corona" index, index/mask types and the collision detector states.
package corona_pkg;

  localparam int NUM_OBJ = 10;
  localparam logic [3:0] NONE_IDX = 4'd15;

  typedef logic [3:0]         obj_idx_t;
  typedef logic [0:NUM_OBJ-1] obj_mask_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    ARMED,
    PENDING,
    HOLDOFF
  } det_state_t;

endpackage

// File: rtl/corona_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set mask bit wins. Reports
// NONE_IDX with vld_o=0 when the mask is empty.
module corona_priority_encoder
  import corona_pkg::*;
(
  input  obj_mask_t mask_i,
  output obj_idx_t  idx_o,
  output logic      vld_o
);

  // Scan downwards so the lowest set index is the last assignment to stick.
  always_comb begin
    idx_o = NONE_IDX;
    vld_o = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = obj_idx_t'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/corona_collision_detector.sv
// Frame-synchronous clamp collision detector: latches the first clamp overlap
// of a frame and reports it at the next frame boundary, followed by a frame
// hold-off. Define COLLISION_BORDER_EN to also treat clamp-over-border as a hit.
module corona_collision_detector
  import corona_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               clampDrawingRequest,
  input  logic [0:NUM_OBJ-1] coronaDrawingRequest,
  input  logic               borderDrawingRequest,
  output logic               collision,
  output logic [3:0]         collision_clamp_corona,
  output logic               holdoffActive
);

  localparam int CNT_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  if (NUM_OBJ > 15) begin : g_num_obj_check
    $error("NUM_OBJ must be <= 15 so every index fits below NONE_IDX");
  end

  det_state_t       state_q, state_d;
  obj_idx_t         latch_q, latch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coll_q, coll_d;
  obj_idx_t         idx_q, idx_d;

  obj_mask_t hit_mask;
  obj_idx_t  cor_idx;
  logic      cor_vld;
  logic      border_hit;
  logic      hit;
  obj_idx_t  hit_idx;

  assign hit_mask = coronaDrawingRequest & {NUM_OBJ{clampDrawingRequest}};

  corona_priority_encoder u_prio (
    .mask_i (hit_mask),
    .idx_o  (cor_idx),
    .vld_o  (cor_vld)
  );

`ifdef COLLISION_BORDER_EN
  assign border_hit = clampDrawingRequest & borderDrawingRequest;
`else
  logic unused_border;
  assign unused_border = borderDrawingRequest;
  assign border_hit    = 1'b0;
`endif

  // A corona on the same pixel outranks the border.
  assign hit     = cor_vld | border_hit;
  assign hit_idx = cor_vld ? cor_idx : NONE_IDX;

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    coll_d  = 1'b0;
    idx_d   = NONE_IDX;
    case (state_q)
      WAIT_SOF: begin
        if (startOfFrame) state_d = ARMED;
      end
      ARMED: begin
        if (hit) begin
          latch_d = hit_idx;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // The boundary pixel itself is never evaluated: the emit owns it.
        if (startOfFrame) begin
          coll_d  = 1'b1;
          idx_d   = latch_q;
          latch_d = NONE_IDX;
          cnt_d   = CNT_W'(HOLDOFF_FRAMES);
          state_d = (HOLDOFF_FRAMES == 0) ? ARMED : HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (startOfFrame) begin
          if (cnt_q <= CNT_W'(1)) begin
            // Counter expires: this new frame is live from its first pixel.
            cnt_d   = '0;
            state_d = ARMED;
            if (hit) begin
              latch_d = hit_idx;
              state_d = PENDING;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= WAIT_SOF;
      latch_q <= NONE_IDX;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      idx_q   <= NONE_IDX;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      idx_q   <= idx_d;
    end
  end

  assign collision              = coll_q;
  assign collision_clamp_corona = idx_q;
  assign holdoffActive          = (cnt_q != '0);

endmodule

// File: tb/tb_corona_collision_detector.sv
// Self-checking bench for corona_collision_detector: directed frames plus
// random frames, checked against a frame-level reference model.
module tb_corona_collision_detector;
  import corona_pkg::*;

  localparam int H = 4;
  localparam int L = 128;
`ifdef COLLISION_BORDER_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic clamp = 1'b0;
  logic border = 1'b0;
  logic [0:NUM_OBJ-1] cor = '0;
  logic collision;
  logic holdoffActive;
  logic [3:0] cidx;

  int checks = 0;
  int failures = 0;

  // Per-frame pixel plan
  logic pc [L];
  logic [0:NUM_OBJ-1] pm [L];
  logic pb [L];

  // Frame-level reference model state
  int g = 0;
  bit seen_sof = 1'b0;
  int elig = 1 << 30;
  bit skip0 = 1'b1;
  bit pend_v = 1'b0;
  int pend_i = 15;
  int ho_first = 1;
  int ho_last = 0;

  always #5 clk = ~clk;

  corona_collision_detector #(.HOLDOFF_FRAMES(H)) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (sof),
    .clampDrawingRequest    (clamp),
    .coronaDrawingRequest   (cor),
    .borderDrawingRequest   (border),
    .collision              (collision),
    .collision_clamp_corona (cidx),
    .holdoffActive          (holdoffActive)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (frame %0d)", tag, obs, exp, g);
    end
  endtask

  function automatic logic [0:NUM_OBJ-1] onehot(input int i);
    logic [0:NUM_OBJ-1] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < L; i++) begin
      pc[i] = 1'b0;
      pm[i] = '0;
      pb[i] = 1'b0;
    end
  endtask

  task automatic set_px(input int p, input logic c, input logic [0:NUM_OBJ-1] m, input logic b);
    pc[p] = c;
    pm[p] = m;
    pb[p] = b;
  endtask

  // First qualifying overlap in the planned frame, scanning pixels in time order.
  function automatic int frame_hit(input int start);
    for (int p = start; p < L; p++) begin
      if (pc[p]) begin
        for (int i = 0; i < NUM_OBJ; i++)
          if (pm[p][i]) return i;
        if (BEN && pb[p]) return 15;
      end
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    sof = 1'b0; clamp = 1'b0; cor = '0; border = 1'b0;
    #1;
    chk("reset_collision", 8'(collision), 8'd0);
    chk("reset_index", 8'(cidx), 8'd15);
    chk("reset_holdoff", 8'(holdoffActive), 8'd0);
    @(negedge clk);
    resetN = 1'b1;
    seen_sof = 1'b0; pend_v = 1'b0; elig = 1 << 30;
    ho_first = 1; ho_last = 0;
  endtask

  task automatic run_idle_overlap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sof = 1'b0; clamp = 1'b1; cor = onehot(4); border = 1'b1;
      @(posedge clk); #1;
      chk("pre_sof_no_pulse", 8'(collision), 8'd0);
    end
  endtask

  task automatic run_frame(input int len);
    bit exp_pulse;
    int exp_idx;
    int h;
    g++;
    exp_pulse = pend_v;
    exp_idx = pend_v ? pend_i : 15;
    pend_v = 1'b0;
    if (!seen_sof) begin
      seen_sof = 1'b1; elig = g; skip0 = 1'b1;
    end else if (exp_pulse) begin
      elig = g + H; skip0 = (H == 0);
      ho_first = g; ho_last = g + H - 1;
    end
    if (g >= elig) begin
      h = frame_hit((g == elig && skip0) ? 1 : 0);
      if (h >= 0) begin
        pend_v = 1'b1; pend_i = h; elig = 1 << 30;
      end
    end
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      sof = (p == 0); clamp = pc[p]; cor = pm[p]; border = pb[p];
      @(posedge clk); #1;
      if (p == 0) begin
        chk("pulse_at_sof", 8'(collision), 8'(exp_pulse));
        chk("index_at_sof", 8'(cidx), 8'(exp_idx));
      end else begin
        chk("no_pulse_midframe", 8'(collision), 8'd0);
        chk("index_idle", 8'(cidx), 8'd15);
      end
      if (p == L / 2)
        chk("holdoff_active", 8'(holdoffActive), 8'(g >= ho_first && g <= ho_last));
    end
  endtask

  task automatic run_empty(input int n);
    clear_plan();
    for (int k = 0; k < n; k++) run_frame(L);
  endtask

  initial begin
    int n;
    int p;
    logic [0:NUM_OBJ-1] m;

    do_reset();
    run_idle_overlap(20);

    // First frame: clamp over corona 3 at pixel 100
    clear_plan(); set_px(100, 1'b1, onehot(3), 1'b0); run_frame(L);
    // Clamp parked on corona 0 through and past the hold-off
    clear_plan(); set_px(20, 1'b1, onehot(0), 1'b0);
    for (int k = 0; k < 9; k++) run_frame(L);
    // First in time wins within a frame
    clear_plan(); set_px(50, 1'b1, onehot(7), 1'b0); set_px(60, 1'b1, onehot(2), 1'b0); run_frame(L);
    run_empty(4);
    // Same pixel: lowest index wins
    clear_plan(); set_px(30, 1'b1, onehot(5) | onehot(1), 1'b0); run_frame(L);
    run_empty(4);
    // Coronas overlapping without clamp, border without clamp
    clear_plan(); set_px(30, 1'b0, onehot(2) | onehot(6) | onehot(8), 1'b1); run_frame(L);
    // Clamp over border alone
    clear_plan(); set_px(40, 1'b1, '0, 1'b1); run_frame(L);
    run_empty(5);
    // Border and corona on the same pixel
    clear_plan(); set_px(40, 1'b1, onehot(9), 1'b1); run_frame(L);
    run_empty(5);
    // Overlap on the start-of-frame pixel while armed
    clear_plan(); set_px(0, 1'b1, onehot(6), 1'b0); run_frame(L);
    run_empty(5);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      clear_plan();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        p = $urandom_range(1, L - 1);
        for (int i = 0; i < NUM_OBJ; i++) m[i] = ($urandom_range(0, 4) == 0);
        set_px(p, ($urandom_range(0, 3) != 0), m, 1'($urandom_range(0, 1)));
      end
      run_frame(L);
    end

    // Reset while an event is pending discards it
    run_empty(6);
    clear_plan(); set_px(10, 1'b1, onehot(4), 1'b0); run_frame(50);
    do_reset();
    run_idle_overlap(5);
    run_empty(2);
    clear_plan(); set_px(70, 1'b1, onehot(8), 1'b0); run_frame(L);
    run_empty(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
